// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arb
//  Description : Shares one WIDTH-bit ALU between two requesters (port 0:
//                execute stage, port 1: address/branch helper). Round-robin
//                grant, operand/control muxing onto the ALU, one-cycle
//                registered result return and ownership of the architectural
//                V/N/Z flag register.
//                Optional feature macro: ALU_SHARE_LOCK_EN (locked grants,
//                bounded by LOCK_MAX consecutive grants to one port).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int WIDTH     = 16,
    parameter int CTRL_W    = 4,
    parameter int FLAG_PORT = 0,
    parameter int LOCK_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // requester 0
    input  logic              req0,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req0_flag_we,
    input  logic              req0_lock,
    output logic              gnt0,
    output logic              rsp0_vld,
    // requester 1
    input  logic              req1,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic              req1_flag_we,
    input  logic              req1_lock,
    output logic              gnt1,
    output logic              rsp1_vld,
    // shared response
    output logic [WIDTH-1:0]  rsp_result,
    // ALU side
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_v,
    input  logic              alu_n,
    input  logic              alu_z,
    // architectural flags
    output logic              flag_v,
    output logic              flag_n,
    output logic              flag_z
);

    localparam int c_CNT_W = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    state_t             r_state_q;
    state_t             w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;
    logic               r_last_gnt_q;
    logic               w_last_gnt_d;
    logic               r_rsp0_vld_q;
    logic               w_rsp0_vld_d;
    logic               r_rsp1_vld_q;
    logic               w_rsp1_vld_d;
    logic [WIDTH-1:0]   r_rsp_result_q;
    logic [WIDTH-1:0]   w_rsp_result_d;
    logic [2:0]         r_flags_q;
    logic [2:0]         w_flags_d;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_flag_load;

    // Grant selection: lock states restrict to the owner, otherwise
    // round-robin with the port that did not win last time taking ties.
    // Grants are suppressed while reset is asserted so nothing is launched.
    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_last_gnt_d = r_last_gnt_q;
        if (!rst) begin
            case (r_state_q)
                ST_LOCK0: w_gnt0 = req0;
                ST_LOCK1: w_gnt1 = req1;
                default: begin
                    if (req0 && req1) begin
                        w_gnt0 = r_last_gnt_q;
                        w_gnt1 = !r_last_gnt_q;
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                end
            endcase
            if (w_gnt0) begin
                w_last_gnt_d = 1'b0;
            end else if (w_gnt1) begin
                w_last_gnt_d = 1'b1;
            end
        end
    end

`ifdef ALU_SHARE_LOCK_EN
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX    = c_CNT_W'(LOCK_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam bit                 c_LOCK_USABLE = (LOCK_MAX > 1);

    logic [c_CNT_W-1:0] w_cnt_inc;

    // Lock FSM: the grant that enters a lock counts as the first locked grant;
    // reaching LOCK_MAX forces a return to arbitration with last_gnt pointing
    // at the locked port so the other port wins the next contention.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_cnt_inc = r_cnt_q + c_CNT_ONE;
        case (r_state_q)
            ST_ARB: begin
                w_cnt_d = '0;
                if (c_LOCK_USABLE && w_gnt0 && req0_lock) begin
                    w_state_d = ST_LOCK0;
                    w_cnt_d   = c_CNT_ONE;
                end else if (c_LOCK_USABLE && w_gnt1 && req1_lock) begin
                    w_state_d = ST_LOCK1;
                    w_cnt_d   = c_CNT_ONE;
                end
            end
            ST_LOCK0: begin
                if (!w_gnt0 || !req0_lock || (w_cnt_inc >= c_LOCK_MAX)) begin
                    w_state_d = ST_ARB;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            ST_LOCK1: begin
                if (!w_gnt1 || !req1_lock || (w_cnt_inc >= c_LOCK_MAX)) begin
                    w_state_d = ST_ARB;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                end
            end
            default: begin
                w_state_d = ST_ARB;
                w_cnt_d   = '0;
            end
        endcase
    end
`else
    logic w_unused_lock;

    // Without locking the FSM never leaves arbitration.
    always_comb begin
        w_state_d = ST_ARB;
        w_cnt_d   = '0;
    end

    assign w_unused_lock = ^{req0_lock, req1_lock, r_cnt_q};
`endif

    // Only the flag-owning port may load flags, and only on its own grant.
    always_comb begin
        if (FLAG_PORT == 0) begin
            w_flag_load = w_gnt0 && req0_flag_we;
        end else begin
            w_flag_load = w_gnt1 && req1_flag_we;
        end
    end

    // Next-state for the response and flag registers.
    always_comb begin
        w_rsp0_vld_d   = w_gnt0;
        w_rsp1_vld_d   = w_gnt1;
        w_rsp_result_d = r_rsp_result_q;
        w_flags_d      = r_flags_q;
        if (w_gnt0 || w_gnt1) begin
            w_rsp_result_d = alu_result;
        end
        if (w_flag_load) begin
            w_flags_d = {alu_v, alu_n, alu_z};
        end
    end

    // Operand/control mux onto the ALU; idle drives zeros.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        if (w_gnt0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (w_gnt1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q      <= ST_ARB;
            r_cnt_q        <= '0;
            r_last_gnt_q   <= 1'b1;
            r_rsp0_vld_q   <= 1'b0;
            r_rsp1_vld_q   <= 1'b0;
            r_rsp_result_q <= '0;
            r_flags_q      <= 3'b000;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_last_gnt_q   <= w_last_gnt_d;
            r_rsp0_vld_q   <= w_rsp0_vld_d;
            r_rsp1_vld_q   <= w_rsp1_vld_d;
            r_rsp_result_q <= w_rsp_result_d;
            r_flags_q      <= w_flags_d;
        end
    end

    assign gnt0       = w_gnt0;
    assign gnt1       = w_gnt1;
    assign rsp0_vld   = r_rsp0_vld_q;
    assign rsp1_vld   = r_rsp1_vld_q;
    assign rsp_result = r_rsp_result_q;
    assign flag_v     = r_flags_q[2];
    assign flag_n     = r_flags_q[1];
    assign flag_z     = r_flags_q[0];

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arb
//  Description : Directed self-checking bench for alu_share_arb with a small
//                behavioural ALU attached to the ALU-side ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        req0_flag_we, req1_flag_we, req0_lock, req1_lock;
    logic        gnt0, gnt1, rsp0_vld, rsp1_vld;
    logic [15:0] rsp_result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_v, alu_n, alu_z;
    logic        flag_v, flag_n, flag_z;

    int checks;
    int errors;

    alu_share_arb #(
        .WIDTH(16), .CTRL_W(4), .FLAG_PORT(0), .LOCK_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req0_flag_we(req0_flag_we), .req0_lock(req0_lock), .gnt0(gnt0), .rsp0_vld(rsp0_vld),
        .req1(req1), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .req1_flag_we(req1_flag_we), .req1_lock(req1_lock), .gnt1(gnt1), .rsp1_vld(rsp1_vld),
        .rsp_result(rsp_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
        .flag_v(flag_v), .flag_n(flag_n), .flag_z(flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU standing in for the real one.
    always_comb begin
        alu_result = 16'h0000;
        alu_v      = 1'b0;
        case (alu_ctrl)
            4'b0000: begin
                alu_result = alu_a + alu_b;
                alu_v = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            4'b1000: alu_result = alu_a ^ alu_b;
            4'b0100: alu_result = ~(alu_a & alu_b);
            4'b1100: alu_result = alu_a << alu_b[3:0];
            4'b1110: alu_result = alu_a >> alu_b[3:0];
            4'b1111: alu_result = 16'($signed(alu_a) >>> alu_b[3:0]);
            default: alu_result = 16'h0000;
        endcase
        alu_n = alu_result[15];
        alu_z = (alu_result == 16'h0000);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req0 = 0; req0_a = 0; req0_b = 0; req0_ctrl = 0; req0_flag_we = 0; req0_lock = 0;
        req1 = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0; req1_flag_we = 0; req1_lock = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt0, gnt1, rsp0_vld, rsp1_vld} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctl: got %b want 0000", {gnt0, gnt1, rsp0_vld, rsp1_vld});
        end
        checks++;
        if (rsp_result !== 16'h0000) begin
            errors++; $display("FAIL reset_result: got %h want 0000", rsp_result);
        end
        checks++;
        if ({flag_v, flag_n, flag_z} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {flag_v, flag_n, flag_z});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_ctrl} !== 36'h0) begin
            errors++; $display("FAIL idle_alu_inputs: got %h want 0", {alu_a, alu_b, alu_ctrl});
        end
    endtask

    task automatic test_add_flags();
        req0 = 1; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_ctrl = 4'b0000; req0_flag_we = 1;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++; $display("FAIL add_gnt: got %b want 10", {gnt0, gnt1});
        end
        checks++;
        if (alu_a !== 16'h7FFF || alu_b !== 16'h0001) begin
            errors++; $display("FAIL add_alu_ops: got %h/%h want 7fff/0001", alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        checks++;
        if ({rsp0_vld, rsp1_vld} !== 2'b10 || rsp_result !== 16'h8000) begin
            errors++; $display("FAIL add_rsp: got vld=%b res=%h want 10/8000", {rsp0_vld, rsp1_vld}, rsp_result);
        end
        checks++;
        if ({flag_v, flag_n, flag_z} !== 3'b110) begin
            errors++; $display("FAIL add_flags: got %b want 110", {flag_v, flag_n, flag_z});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rsp0_vld, rsp1_vld} !== 2'b00) begin
            errors++; $display("FAIL add_vld_pulse: got %b want 00", {rsp0_vld, rsp1_vld});
        end
    endtask

    task automatic test_flag_port();
        req1 = 1; req1_a = 16'h00FF; req1_b = 16'h00FF; req1_ctrl = 4'b1000; req1_flag_we = 1;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++; $display("FAIL xor_gnt: got %b want 01", {gnt0, gnt1});
        end
        @(posedge clk);
        #1;
        idle_inputs();
        checks++;
        if ({rsp0_vld, rsp1_vld} !== 2'b01 || rsp_result !== 16'h0000) begin
            errors++; $display("FAIL xor_rsp: got vld=%b res=%h want 01/0000", {rsp0_vld, rsp1_vld}, rsp_result);
        end
        checks++;
        if ({flag_v, flag_n, flag_z} !== 3'b110) begin
            errors++; $display("FAIL xor_flags_held: got %b want 110", {flag_v, flag_n, flag_z});
        end
    endtask

    task automatic test_reset_in_grant();
        @(posedge clk);
        #1;
        req0 = 1; req0_a = 16'hF000; req0_b = 16'h0004; req0_ctrl = 4'b1111; req0_flag_we = 1;
        rst = 1;
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++; $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1});
        end
        @(posedge clk);
        #1;
        checks++;
        if (rsp0_vld !== 1'b0 || rsp_result !== 16'h0000 || {flag_v, flag_n, flag_z} !== 3'b000) begin
            errors++; $display("FAIL rst_discard: got vld=%b res=%h flags=%b want 0/0000/000",
                               rsp0_vld, rsp_result, {flag_v, flag_n, flag_z});
        end
        rst = 0;
        @(posedge clk);
        #1;
        idle_inputs();
        checks++;
        if (rsp0_vld !== 1'b1 || rsp_result !== 16'hFF00 || {flag_v, flag_n, flag_z} !== 3'b010) begin
            errors++; $display("FAIL sra_after_rst: got vld=%b res=%h flags=%b want 1/ff00/010",
                               rsp0_vld, rsp_result, {flag_v, flag_n, flag_z});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat;
        pat = 4'b1010;
        apply_reset();
        req0 = 1; req0_a = 16'h0001; req0_b = 16'h0002; req0_ctrl = 4'b0000;
        req1 = 1; req1_a = 16'h0F0F; req1_b = 16'h00FF; req1_ctrl = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({gnt0, gnt1} !== {!pat[i], pat[i]}) begin
                errors++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {!pat[i], pat[i]});
            end
            @(posedge clk);
            #1;
            if (i == 3) idle_inputs();
            checks++;
            if ({rsp0_vld, rsp1_vld} !== {!pat[i], pat[i]} ||
                rsp_result !== (pat[i] ? 16'h0FF0 : 16'h0003)) begin
                errors++; $display("FAIL b2b_rsp[%0d]: got vld=%b res=%h want %b/%h", i,
                                   {rsp0_vld, rsp1_vld}, rsp_result, {!pat[i], pat[i]},
                                   pat[i] ? 16'h0FF0 : 16'h0003);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rsp0_vld, rsp1_vld} !== 2'b00) begin
            errors++; $display("FAIL b2b_end: got %b want 00", {rsp0_vld, rsp1_vld});
        end
    endtask

    // Port 0 requests with lock held while port 1 also requests.
    task automatic test_lock();
        logic [5:0] pat;
`ifdef ALU_SHARE_LOCK_EN
        pat = 6'b010000;
`else
        pat = 6'b101010;
`endif
        apply_reset();
        req0 = 1; req0_a = 16'h0005; req0_b = 16'h0005; req0_ctrl = 4'b0000; req0_lock = 1;
        req1 = 1; req1_a = 16'hAAAA; req1_b = 16'h5555; req1_ctrl = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({gnt0, gnt1} !== {!pat[i], pat[i]}) begin
                errors++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {!pat[i], pat[i]});
            end
            @(posedge clk);
            #1;
            checks++;
            if ({rsp0_vld, rsp1_vld} !== {!pat[i], pat[i]} ||
                rsp_result !== (pat[i] ? 16'hFFFF : 16'h000A)) begin
                errors++; $display("FAIL lock_rsp[%0d]: got vld=%b res=%h want %b/%h", i,
                                   {rsp0_vld, rsp1_vld}, rsp_result, {!pat[i], pat[i]},
                                   pat[i] ? 16'hFFFF : 16'h000A);
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_add_flags();
        test_flag_port();
        test_reset_in_grant();
        test_back_to_back();
        test_lock();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
